// File: rtl/instr_fetch_unit_if.sv
// Command/status bundle between the CPU control unit and the instruction fetch unit.
interface instr_fetch_unit_if #(
  parameter int PC_W = 8,
  parameter int IR_W = 16
);
  logic            pc_clr;
  logic            pc_ic;
  logic            pc_ld;
  logic [PC_W-1:0] pc_ld_val;
  logic            pr_id;
  logic            prog_we;
  logic [PC_W-1:0] prog_addr;
  logic [IR_W-1:0] prog_data;
  logic [IR_W-1:0] ir;
  logic            ir_valid;
  logic            fetch_busy;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            fetch_err;

  modport master (
    output pc_clr, pc_ic, pc_ld, pc_ld_val, pr_id, prog_we, prog_addr, prog_data,
    input  ir, ir_valid, fetch_busy, pc, halted, fetch_err
  );

  modport slave (
    input  pc_clr, pc_ic, pc_ld, pc_ld_val, pr_id, prog_we, prog_addr, prog_data,
    output ir, ir_valid, fetch_busy, pc, halted, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter, synchronous instruction memory and instruction register with a
// three-state fetch sequencer (IDLE -> READ -> LATCH) and sticky halt/error flags.
module instr_fetch_unit #(
  parameter int       PC_W    = 8,
  parameter int       IR_W    = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  logic [1:0]      state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] addr_q;
  logic [IR_W-1:0] mem_q;
  logic [IR_W-1:0] ir_q;
  logic            ir_valid_q;
  logic            busy_q;
  logic            halted_q;
  logic            err_q;
  logic [IR_W-1:0] mem [0:(1<<PC_W)-1];

  logic accept;
  logic reject;
  logic halt_hit;

  assign accept   = (state == IDLE) && bus.pr_id && !halted_q;
  assign reject   = bus.pr_id && ((state != IDLE) || halted_q);
  assign halt_hit = (state == LATCH) && (mem_q[IR_W-1 -: 4] == HALT_OP);

  // PC runs independently of the sequencer; a fetch already owns its captured address.
  always_ff @(posedge clk) begin
    if (rst)              pc_q <= '0;
    else if (bus.pc_clr)  pc_q <= '0;
    else if (bus.pc_ld)   pc_q <= bus.pc_ld_val;
    else if (bus.pc_ic)   pc_q <= pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= pc_q;
            state  <= READ;
            busy_q <= 1'b1;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          ir_q       <= mem_q;
          ir_valid_q <= 1'b1;
          state      <= IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // A same-edge set beats PC_CLR so a halting word latched on that edge is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      halted_q <= (halted_q & ~bus.pc_clr) | halt_hit;
      err_q    <= (err_q & ~bus.pc_clr) | reject;
    end
  end

  // Read-first: a write to the address being read lands after MEM_Q samples old data.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    if (state == READ) mem_q <= mem[addr_q];
  end

  assign bus.ir         = ir_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.fetch_busy = busy_q;
  assign bus.pc         = pc_q;
  assign bus.halted     = halted_q;
  assign bus.fetch_err  = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: PC op table, scoreboard of fetched words, hand-written corner sequences.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.PC_W(8), .IR_W(16)) bus ();

  instr_fetch_unit #(.PC_W(8), .IR_W(16), .HALT_OP(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       clr;
    logic       ld;
    logic       ic;
    logic [7:0] val;
    logic [7:0] pc;
  } pc_vec_t;

  pc_vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every IR_VALID pulse must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (bus.ir_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_ir_valid: got ir=%0h expected no pulse", bus.ir);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.ir !== e) begin
          mismatched++;
          $display("FAIL scoreboard_ir: got %0h expected %0h", bus.ir, e);
        end
      end
    end
  end

  task automatic prog(input logic [7:0] a, input logic [15:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    step();
    bus.prog_we = 1'b0;
  endtask

  task automatic load_pc(input logic [7:0] v);
    bus.pc_ld = 1'b1; bus.pc_ld_val = v;
    step();
    bus.pc_ld = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] e);
    bus.pr_id = 1'b1;
    exp_q.push_back(e);
    step();
    bus.pr_id = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    tbl[0] = '{0, 1, 0, 8'hFF, 8'hFF};
    tbl[1] = '{0, 0, 1, 8'h00, 8'h00};
    tbl[2] = '{0, 1, 0, 8'h05, 8'h05};
    tbl[3] = '{1, 1, 1, 8'h09, 8'h00};
    tbl[4] = '{0, 1, 1, 8'h07, 8'h07};
    tbl[5] = '{0, 0, 1, 8'h00, 8'h08};
    tbl[6] = '{0, 0, 0, 8'h00, 8'h08};
    tbl[7] = '{1, 0, 1, 8'h00, 8'h00};

    rst = 1'b1;
    bus.pc_clr = 0; bus.pc_ic = 0; bus.pc_ld = 0; bus.pc_ld_val = '0;
    bus.pr_id = 0; bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    step(); step();
    check("rst_pc", bus.pc, 0);
    check("rst_ir", bus.ir, 0);
    check("rst_ir_valid", bus.ir_valid, 0);
    check("rst_busy", bus.fetch_busy, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_err", bus.fetch_err, 0);
    rst = 1'b0;

    prog(8'd0, 16'h1234);
    prog(8'd1, 16'h2345);
    prog(8'd2, 16'h0000);
    prog(8'd3, 16'hF000);

    // Basic fetch with latency/busy checks
    bus.pr_id = 1'b1; exp_q.push_back(16'h1234);
    step();
    bus.pr_id = 1'b0;
    check("busy_c1", bus.fetch_busy, 1);
    check("valid_c1", bus.ir_valid, 0);
    step();
    check("busy_c2", bus.fetch_busy, 1);
    step();
    check("busy_c3", bus.fetch_busy, 0);
    check("valid_c3", bus.ir_valid, 1);
    check("ir_c3", bus.ir, 16'h1234);
    check("pc_after_fetch", bus.pc, 0);
    step();
    check("valid_one_cycle", bus.ir_valid, 0);
    check("ir_holds", bus.ir, 16'h1234);

    // Fetch uses the old PC while PC increments on the same edge
    bus.pr_id = 1'b1; bus.pc_ic = 1'b1; exp_q.push_back(16'h1234);
    step();
    bus.pr_id = 1'b0; bus.pc_ic = 1'b0;
    check("pc_inc_with_fetch", bus.pc, 1);
    step(); step(); step();
    fetch(16'h2345);
    check("ir_second", bus.ir, 16'h2345);

    for (int i = 0; i < 8; i++) begin
      bus.pc_clr = tbl[i].clr; bus.pc_ld = tbl[i].ld; bus.pc_ic = tbl[i].ic;
      bus.pc_ld_val = tbl[i].val;
      step();
      check($sformatf("pc_tbl%0d", i), bus.pc, tbl[i].pc);
    end
    bus.pc_clr = 0; bus.pc_ld = 0; bus.pc_ic = 0;

    // Halt detection, rejected fetch, recovery via PC_CLR
    load_pc(8'd3);
    fetch(16'hF000);
    check("halted_set", bus.halted, 1);
    bus.pr_id = 1'b1;
    step();
    bus.pr_id = 1'b0;
    check("err_on_halted", bus.fetch_err, 1);
    check("busy_on_halted", bus.fetch_busy, 0);
    step(); step(); step();
    bus.pc_clr = 1'b1;
    step();
    bus.pc_clr = 1'b0;
    check("halted_clr", bus.halted, 0);
    check("err_clr", bus.fetch_err, 0);
    check("pc_clr", bus.pc, 0);
    fetch(16'h1234);
    check("fetch_after_clr", bus.ir, 16'h1234);

    // PR_ID held into READ: second request rejected
    bus.pr_id = 1'b1; exp_q.push_back(16'h1234);
    step();
    step();
    bus.pr_id = 1'b0;
    check("err_busy", bus.fetch_err, 1);
    step(); step(); step(); step();
    check("ir_first_only", bus.ir, 16'h1234);

    // Reset while in LATCH aborts the fetch
    load_pc(8'd1);
    bus.pr_id = 1'b1;
    step();
    bus.pr_id = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort_ir", bus.ir, 0);
    check("abort_valid", bus.ir_valid, 0);
    check("abort_busy", bus.fetch_busy, 0);
    check("abort_pc", bus.pc, 0);
    check("abort_err", bus.fetch_err, 0);
    rst = 1'b0;
    step();
    check("abort_valid2", bus.ir_valid, 0);
    step();

    // Write during READ of the same address is read-first
    load_pc(8'd2);
    bus.pr_id = 1'b1; exp_q.push_back(16'h0000);
    step();
    bus.pr_id = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = 8'd2; bus.prog_data = 16'hBEEF;
    step();
    bus.prog_we = 1'b0;
    step();
    check("raw_old", bus.ir, 16'h0000);
    step();
    fetch(16'hBEEF);
    check("raw_new", bus.ir, 16'hBEEF);

    step(); step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side responder to the CPU control unit's PC/IR command lines (PC_CLR, PR_ID, PC_IC).
- Owns the program counter, a synchronous instruction memory and the instruction register.
- Returns the fetched word on IR with a valid strobe and a busy flag.
- Also provides a program-load write port for boot/bench, PC load for jumps, and sticky halt detection.

Parameters:
- PC_W, 8, program counter and instruction-memory address width (depth 2^PC_W).
- IR_W, 16, instruction word width.
- HALT_OP, 4'hF, opcode value in IR[IR_W-1:IR_W-4] that sets HALTED.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PC_CLR  in  1  clear PC to 0; also clears HALTED and FETCH_ERR.
- PC_IC  in  1  increment PC by 1.
- PC_LD  in  1  load PC from PC_LD_VAL.
- PC_LD_VAL  in  PC_W  jump target.
- PR_ID  in  1  fetch request: read memory at PC into IR.
- PROG_WE  in  1  instruction-memory write enable.
- PROG_ADDR  in  PC_W  write address.
- PROG_DATA  in  IR_W  write data.
- IR  out  IR_W  instruction register.
- IR_VALID  out  1  one-cycle pulse when IR is updated.
- FETCH_BUSY  out  1  high while a fetch is in flight.
- PC  out  PC_W  current program counter.
- HALTED  out  1  sticky: last latched opcode == HALT_OP.
- FETCH_ERR  out  1  sticky: PR_ID received while busy or halted.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - PC=0, IR=0, IR_VALID=0, FETCH_BUSY=0, HALTED=0, FETCH_ERR=0, FSM to IDLE.
  - Any in-flight fetch is aborted; no IR_VALID follows.
  - Memory contents are not cleared.
- PC update, priority PC_CLR > PC_LD > PC_IC:
  - PC_CLR: PC <= 0.
  - PC_LD: PC <= PC_LD_VAL.
  - PC_IC: PC <= PC+1, mod 2^PC_W (wrap: 8'hFF -> 8'h00).
  - None asserted: PC holds.
- PC updates are independent of the fetch FSM.
- FSM states IDLE, READ, LATCH:
  - IDLE: on PR_ID=1 with HALTED=0, capture ADDR_Q <= PC (value before any same-edge PC update) and go to READ.
  - READ: MEM_Q <= mem[ADDR_Q]; go to LATCH.
  - LATCH: IR <= MEM_Q; IR_VALID <= 1 for exactly one cycle; HALTED <= 1 if the new opcode == HALT_OP; go to IDLE.
- Latency: PR_ID sampled at edge k gives IR and IR_VALID visible after edge k+2.
- Back-to-back fetches: a new PR_ID can be accepted in the cycle IR_VALID is high, so throughput is one fetch per 3 cycles.
- FETCH_BUSY = (state != IDLE), registered.
- PR_ID while busy or HALTED: ignored; FETCH_ERR <= 1 (sticky until Reset or PC_CLR).
- Simultaneous PR_ID and PC_IC in IDLE: the fetch uses the old PC; PC increments.
- PC_CLR/PC_LD mid-fetch: the fetch completes from its captured address.
  - PC_CLR clears HALTED/FETCH_ERR on that edge.
  - If the same fetch later latches HALT_OP, HALTED sets again.
- Memory write: mem[PROG_ADDR] <= PROG_DATA when PROG_WE=1, in any state.
  - Same-cycle write and READ of the same address is read-first: MEM_Q gets the old data.
- IR holds its value between fetches; IR_VALID=0 except on the LATCH-exit cycle.

Test Plan:
- Reset, then load mem[0]=16'h1234, mem[1]=16'h2345; pulse PR_ID at PC=0 -> FETCH_BUSY high 2 cycles; IR=16'h1234 with a one-cycle IR_VALID 2 edges after PR_ID; PC=0.
- PR_ID+PC_IC on the same edge at PC=0 -> IR=16'h1234, PC=1; next PR_ID -> IR=16'h2345.
- PC_LD_VAL=8'hFF, PC_LD=1, then PC_IC -> PC=8'h00; PC_CLR, PC_LD and PC_IC together at PC=5 -> PC=0.
- mem[3]=16'hF000; fetch at PC=3 -> HALTED=1; subsequent PR_ID -> no IR_VALID, FETCH_ERR=1; PC_CLR -> HALTED=0, FETCH_ERR=0, next fetch proceeds.
- PR_ID in READ state -> ignored, FETCH_ERR=1, IR from the first fetch only; Reset asserted in LATCH -> IR=0, IR_VALID never pulses, all outputs at reset values.
- PROG_WE writing mem[2]=16'hBEEF in the same cycle as READ of address 2 (old value 16'h0) -> IR=16'h0000; a refetch gives IR=16'hBEEF.
